db_read_addr_gen: RTL

Affine read-address generator that sits directly upstream of the double-buffer memory core's read port. It walks up to six nested loop dimensions using the same stride/range configuration the memory core receives. Each generated address is presented to the core under a valid/ready handshake, with ren_in driven from the handshake. It signals completion of a full tile so the surrounding logic can issue switch_db.

---
 rtl/db_read_addr_gen.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/db_read_addr_gen.sv
// ---------------------------------------------------------------------------
// db_read_addr_gen
//
// Purpose:
//   Affine read-address generator for the read port of the double-buffer
//   memory core. It walks up to DIMS nested loops and presents one address
//   per valid/ready handshake. The address is updated incrementally from
//   per-dimension strides. A one-cycle done pulse marks the end of a tile so
//   the surrounding logic can issue switch_db.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   clk_en              global enable; low freezes every register
//   flush               synchronous abort back to IDLE (no done pulse)
//   start               begin a tile walk (honoured only in IDLE)
//   dimensionality      active loop count (0 -> 1, >DIMS -> DIMS)
//   starting_addr       base address of the walk
//   stride_0..stride_5  per-dimension address stride
//   range_0..range_5    per-dimension iteration count (0 -> 1)
//   addr_out            current read address
//   addr_valid          addr_out valid (feeds ren_in of the core)
//   addr_ready          consumer accepts addr_out this cycle
//   busy                high while walking (RUN)
//   done                one-cycle pulse after the final address is accepted
//   issued_cnt          addresses accepted in the current/last walk
// ---------------------------------------------------------------------------
module db_read_addr_gen #(
  parameter int DIMS = 6,
  parameter int AW   = 16,
  parameter int RW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          flush,
  input  logic          start,
  input  logic [3:0]    dimensionality,
  input  logic [AW-1:0] starting_addr,
  input  logic [AW-1:0] stride_0,
  input  logic [AW-1:0] stride_1,
  input  logic [AW-1:0] stride_2,
  input  logic [AW-1:0] stride_3,
  input  logic [AW-1:0] stride_4,
  input  logic [AW-1:0] stride_5,
  input  logic [RW-1:0] range_0,
  input  logic [RW-1:0] range_1,
  input  logic [RW-1:0] range_2,
  input  logic [RW-1:0] range_3,
  input  logic [RW-1:0] range_4,
  input  logic [RW-1:0] range_5,
  output logic [AW-1:0] addr_out,
  output logic          addr_valid,
  input  logic          addr_ready,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] issued_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  state_t        w_stateNext;

  // Shadow configuration: last index of each loop (inactive dims forced to 0),
  // stride, and the address rewind applied when that loop wraps.
  logic [RW-1:0] r_rangeM1 [DIMS];
  logic [AW-1:0] r_stride  [DIMS];
  logic [AW-1:0] r_rewind  [DIMS];
  logic [RW-1:0] r_cnt     [DIMS];
  logic [AW-1:0] r_addr;
  logic [RW-1:0] r_issued;

  logic [AW-1:0] w_strideIn  [DIMS];
  logic [RW-1:0] w_rangeIn   [DIMS];
  logic [RW-1:0] w_rangeM1In [DIMS];
  logic [AW-1:0] w_rewindIn  [DIMS];
  logic [3:0]    w_dimsIn;
  logic [RW-1:0] w_cntNext   [DIMS];
  logic [AW-1:0] w_delta;
  logic          w_last;
  logic          w_carry;
  logic          w_run;
  logic          w_hs;
  logic          w_launch;

  assign w_strideIn[0] = stride_0;
  assign w_strideIn[1] = stride_1;
  assign w_strideIn[2] = stride_2;
  assign w_strideIn[3] = stride_3;
  assign w_strideIn[4] = stride_4;
  assign w_strideIn[5] = stride_5;
  assign w_rangeIn[0]  = range_0;
  assign w_rangeIn[1]  = range_1;
  assign w_rangeIn[2]  = range_2;
  assign w_rangeIn[3]  = range_3;
  assign w_rangeIn[4]  = range_4;
  assign w_rangeIn[5]  = range_5;

  assign w_run    = (r_state == RUN);
  assign w_hs     = w_run & addr_ready & clk_en;
  assign w_launch = (r_state == IDLE) & start & ~flush;

  // Normalise the incoming configuration so the walk logic never has to
  // special-case zero ranges or inactive dimensions: those loops get a last
  // index of 0 and therefore wrap on every carry with a zero rewind. Only the
  // low AW bits of the rewind product matter because addresses wrap mod 2^AW.
  always_comb begin
    if (dimensionality == 4'd0)
      w_dimsIn = 4'd1;
    else if (int'(dimensionality) > DIMS)
      w_dimsIn = 4'(DIMS);
    else
      w_dimsIn = dimensionality;
    for (int i = 0; i < DIMS; i++) begin
      w_rangeM1In[i] = '0;
      if (i < int'(w_dimsIn) && w_rangeIn[i] != '0)
        w_rangeM1In[i] = w_rangeIn[i] - 1'b1;
      w_rewindIn[i] = w_rangeM1In[i][AW-1:0] * w_strideIn[i];
    end
  end

  // Ripple the increment through the loops: every wrapping loop rewinds its
  // contribution, the first non-wrapping loop advances by one stride. If every
  // loop wraps, the current address is the last one of the tile.
  always_comb begin
    w_carry = 1'b1;
    w_delta = '0;
    for (int i = 0; i < DIMS; i++) begin
      w_cntNext[i] = r_cnt[i];
      if (w_carry) begin
        if (r_cnt[i] == r_rangeM1[i]) begin
          w_cntNext[i] = '0;
          w_delta      = w_delta - r_rewind[i];
        end else begin
          w_cntNext[i] = r_cnt[i] + 1'b1;
          w_delta      = w_delta + r_stride[i];
          w_carry      = 1'b0;
        end
      end
    end
    w_last = w_carry;
  end

  // State register; clk_en gates every transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else if (clk_en)
      r_state <= w_stateNext;
  end

  // Next-state logic; flush overrides start and the handshake.
  always_comb begin
    w_stateNext = r_state;
    if (flush) begin
      w_stateNext = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (start) w_stateNext = RUN;
        RUN:     if (w_hs && w_last) w_stateNext = DONE;
        DONE:    w_stateNext = IDLE;
        default: w_stateNext = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; addr_valid falls together with busy.
  always_comb begin
    addr_valid = w_run;
    busy       = w_run;
    done       = (r_state == DONE);
    addr_out   = r_addr;
    issued_cnt = r_issued;
  end

  // Datapath: shadow config, loop counters, running address and accept count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_issued <= '0;
      for (int i = 0; i < DIMS; i++) begin
        r_cnt[i]     <= '0;
        r_rangeM1[i] <= '0;
        r_stride[i]  <= '0;
        r_rewind[i]  <= '0;
      end
    end else if (clk_en) begin
      if (flush) begin
        for (int i = 0; i < DIMS; i++) r_cnt[i] <= '0;
      end else if (w_launch) begin
        r_addr   <= starting_addr;
        r_issued <= '0;
        for (int i = 0; i < DIMS; i++) begin
          r_cnt[i]     <= '0;
          r_rangeM1[i] <= w_rangeM1In[i];
          r_stride[i]  <= w_strideIn[i];
          r_rewind[i]  <= w_rewindIn[i];
        end
      end else if (w_hs) begin
        r_addr   <= r_addr + w_delta;
        r_issued <= r_issued + 1'b1;
        for (int i = 0; i < DIMS; i++) r_cnt[i] <= w_cntNext[i];
      end
    end
  end

endmodule
